// File: rtl/fpu_me_wb_regfile_if.sv
// rtl/fpu_me_wb_regfile_if.sv - ME/WB stage bus: ME inputs, forwarding read ports, WB state
interface fpu_me_wb_regfile_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
);
  logic             me_valid;
  logic [DSIZE-1:0] me_result;
  logic [ASIZE-1:0] me_rd_addr;
  logic             stall;
  logic [ASIZE-1:0] rs1_addr;
  logic [ASIZE-1:0] rs2_addr;
  logic [DSIZE-1:0] rs1_data;
  logic [DSIZE-1:0] rs2_data;
  logic             wb_valid;
  logic [DSIZE-1:0] wb_result;
  logic [ASIZE-1:0] wb_rd_addr;
  logic [CSIZE-1:0] retire_count;

  modport master (
    output me_valid, me_result, me_rd_addr, stall, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_result, wb_rd_addr, retire_count
  );

  modport slave (
    input  me_valid, me_result, me_rd_addr, stall, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_result, wb_rd_addr, retire_count
  );
endinterface

// File: rtl/fpu_me_wb_regfile.sv
// rtl/fpu_me_wb_regfile.sv - FPU ME/WB stage with register file commit and operand forwarding
module fpu_me_wb_regfile #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fpu_me_wb_regfile_if.slave   bus
);
  localparam int DEPTH = 2 ** ASIZE;

  logic             wb_valid_q, wb_valid_d;
  logic [DSIZE-1:0] wb_result_q, wb_result_d;
  logic [ASIZE-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [CSIZE-1:0] retire_q, retire_d;
  logic             commit;
  logic [DSIZE-1:0] regs_q [DEPTH];

  // Commit uses the WB contents from before the edge, so a stalled result retires exactly once.
  always_comb begin
    commit       = wb_valid_q && !bus.stall;
    wb_valid_d   = wb_valid_q;
    wb_result_d  = wb_result_q;
    wb_rd_addr_d = wb_rd_addr_q;
    if (!bus.stall) begin
      wb_valid_d   = bus.me_valid;
      wb_result_d  = bus.me_result;
      wb_rd_addr_d = bus.me_rd_addr;
    end
    retire_d = commit ? retire_q + CSIZE'(1) : retire_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_q   <= 1'b0;
      wb_result_q  <= '0;
      wb_rd_addr_q <= '0;
      retire_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_result_q  <= wb_result_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      retire_q     <= retire_d;
      if (commit) begin
        regs_q[wb_rd_addr_q] <= wb_result_q;
      end
    end
  end

  // Youngest producer wins: ME, then WB, then the committed register file.
  assign bus.rs1_data = (bus.me_valid && bus.rs1_addr == bus.me_rd_addr) ? bus.me_result :
                        (wb_valid_q && bus.rs1_addr == wb_rd_addr_q)     ? wb_result_q   :
                        regs_q[bus.rs1_addr];
  assign bus.rs2_data = (bus.me_valid && bus.rs2_addr == bus.me_rd_addr) ? bus.me_result :
                        (wb_valid_q && bus.rs2_addr == wb_rd_addr_q)     ? wb_result_q   :
                        regs_q[bus.rs2_addr];

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_result    = wb_result_q;
  assign bus.wb_rd_addr   = wb_rd_addr_q;
  assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_fpu_me_wb_regfile.sv
// tb/tb_fpu_me_wb_regfile.sv - self-checking bench for fpu_me_wb_regfile
module tb_fpu_me_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fpu_me_wb_regfile_if #(.DSIZE(DW), .ASIZE(AW), .CSIZE(CW)) bus ();

  fpu_me_wb_regfile #(.DSIZE(DW), .ASIZE(AW), .CSIZE(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: committed registers, a single in-flight WB slot and a plain retire tally.
  logic [DW-1:0] ref_rf [32];
  bit            m_wb_valid;
  logic [DW-1:0] m_wb_result;
  logic [AW-1:0] m_wb_rd;
  int            m_cnt;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (bus.me_valid && a == bus.me_rd_addr) return bus.me_result;
    if (m_wb_valid && a == m_wb_rd) return m_wb_result;
    return ref_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    m_wb_valid = 0;
    m_wb_result = '0;
    m_wb_rd = '0;
    m_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.me_valid = 0;
    bus.me_result = '0;
    bus.me_rd_addr = '0;
    bus.stall = 0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!bus.stall) begin
      if (m_wb_valid) begin
        ref_rf[m_wb_rd] = m_wb_result;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_wb_valid = bus.me_valid;
      m_wb_result = bus.me_result;
      m_wb_rd = bus.me_rd_addr;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #3;
    n_cmp++;
    if ({bus.wb_valid, bus.wb_rd_addr, bus.wb_result} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: got v=%b rd=%0d res=%h want all zero", bus.wb_valid, bus.wb_rd_addr, bus.wb_result);
    end
    n_cmp++;
    if (bus.retire_count !== '0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", bus.retire_count);
    end
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rs1_addr = AW'($urandom);
      bus.rs2_addr = AW'($urandom);
      #1;
      n_cmp++;
      if ({bus.rs1_data, bus.rs2_data} !== '0) begin
        n_err++;
        $display("FAIL reset_regs: got rs1=%h rs2=%h want 0", bus.rs1_data, bus.rs2_data);
      end
    end
  endtask

  task automatic test_forward_basic();
    do_reset();
    bus.me_valid = 1;
    bus.me_result = 32'hAFAB0000;
    bus.me_rd_addr = 30;
    bus.rs1_addr = 30;
    #1;
    n_cmp++;
    if (bus.rs1_data !== 32'hAFAB0000) begin
      n_err++;
      $display("FAIL fwd_me: got %h want afab0000", bus.rs1_data);
    end
    tick();
    bus.me_valid = 0;
    bus.me_result = '0;
    bus.me_rd_addr = '0;
    #1;
    n_cmp++;
    if ({bus.wb_valid, bus.wb_rd_addr, bus.rs1_data} !== {1'b1, 5'd30, 32'hAFAB0000}) begin
      n_err++;
      $display("FAIL fwd_wb: got v=%b rd=%0d rs1=%h want v=1 rd=30 rs1=afab0000", bus.wb_valid, bus.wb_rd_addr, bus.rs1_data);
    end
    tick();
    n_cmp++;
    if ({bus.wb_valid, bus.rs1_data, bus.retire_count} !== {1'b0, 32'hAFAB0000, 16'd1}) begin
      n_err++;
      $display("FAIL commit_r30: got v=%b rs1=%h cnt=%0d want v=0 rs1=afab0000 cnt=1", bus.wb_valid, bus.rs1_data, bus.retire_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rs1_addr = 5;
    bus.rs2_addr = 5;
    bus.me_valid = 1;
    bus.me_rd_addr = 5;
    bus.me_result = 32'h3F800000;
    tick();
    bus.me_result = 32'h40000000;
    #1;
    n_cmp++;
    if ({bus.rs1_data, bus.rs2_data} !== {2{32'h40000000}}) begin
      n_err++;
      $display("FAIL b2b_inflight1: got rs1=%h rs2=%h want 40000000", bus.rs1_data, bus.rs2_data);
    end
    tick();
    bus.me_valid = 0;
    bus.me_result = '0;
    #1;
    n_cmp++;
    if ({bus.rs1_data, bus.rs2_data} !== {2{32'h40000000}}) begin
      n_err++;
      $display("FAIL b2b_inflight2: got rs1=%h rs2=%h want 40000000", bus.rs1_data, bus.rs2_data);
    end
    tick();
    n_cmp++;
    if ({bus.wb_valid, bus.rs1_data, bus.retire_count} !== {1'b0, 32'h40000000, 16'd2}) begin
      n_err++;
      $display("FAIL b2b_final: got v=%b r5=%h cnt=%0d want v=0 r5=40000000 cnt=2", bus.wb_valid, bus.rs1_data, bus.retire_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.rs1_addr = 7;
    bus.me_valid = 1;
    bus.me_rd_addr = 7;
    bus.me_result = 32'h12345678;
    tick();
    bus.me_valid = 0;
    bus.me_result = 32'hCAFEF00D;
    bus.me_rd_addr = 7;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.wb_valid, bus.wb_rd_addr, bus.wb_result, bus.retire_count, bus.rs1_data} !==
          {1'b1, 5'd7, 32'h12345678, 16'd0, 32'h12345678}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b rd=%0d res=%h cnt=%0d rs1=%h want v=1 rd=7 res=12345678 cnt=0 rs1=12345678",
                 i, bus.wb_valid, bus.wb_rd_addr, bus.wb_result, bus.retire_count, bus.rs1_data);
      end
    end
    bus.stall = 0;
    tick();
    tick();
    n_cmp++;
    if ({bus.retire_count, bus.rs1_data} !== {16'd1, 32'h12345678}) begin
      n_err++;
      $display("FAIL stall_release: got cnt=%0d r7=%h want cnt=1 r7=12345678", bus.retire_count, bus.rs1_data);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    bus.me_valid = 0;
    bus.me_rd_addr = 3;
    bus.me_result = 32'hDEADBEEF;
    bus.rs1_addr = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.rs1_data, bus.retire_count} !== {32'd0, 16'd0}) begin
        n_err++;
        $display("FAIL invalid_%0d: got rs1=%h cnt=%0d want 0 0", i, bus.rs1_data, bus.retire_count);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.me_valid = 1;
    bus.me_rd_addr = 9;
    bus.me_result = $urandom | 32'h1;
    tick();
    bus.me_valid = 0;
    bus.rs1_addr = 9;
    n_cmp++;
    if ({bus.wb_valid, bus.wb_rd_addr} !== {1'b1, 5'd9}) begin
      n_err++;
      $display("FAIL arst_pre: got v=%b rd=%0d want v=1 rd=9", bus.wb_valid, bus.wb_rd_addr);
    end
    #2;
    rst = 1;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.wb_valid, bus.wb_result, bus.retire_count} !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: got v=%b res=%h cnt=%0d want 0", bus.wb_valid, bus.wb_result, bus.retire_count);
    end
    @(posedge clk);
    #3;
    rst = 0;
    tick();
    tick();
    n_cmp++;
    if ({bus.rs1_data, bus.retire_count} !== {32'd0, 16'd0}) begin
      n_err++;
      $display("FAIL arst_after: got r9=%h cnt=%0d want 0 0", bus.rs1_data, bus.retire_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.me_valid = ($urandom_range(0, 3) != 0);
      bus.me_result = $urandom;
      bus.me_rd_addr = AW'($urandom_range(0, 7));
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.rs1_addr = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      bus.rs2_addr = AW'($urandom_range(0, 7));
      #1;
      n_cmp++;
      if ({bus.rs1_data, bus.rs2_data} !== {exp_rd(bus.rs1_addr), exp_rd(bus.rs2_addr)}) begin
        n_err++;
        $display("FAIL rand_read%0d: got rs1=%h rs2=%h want rs1=%h rs2=%h", i, bus.rs1_data, bus.rs2_data,
                 exp_rd(bus.rs1_addr), exp_rd(bus.rs2_addr));
      end
      tick();
      n_cmp++;
      if ({bus.wb_valid, bus.wb_rd_addr, bus.wb_result, bus.retire_count} !==
          {m_wb_valid, m_wb_rd, m_wb_result, CW'(m_cnt)}) begin
        n_err++;
        $display("FAIL rand_wb%0d: got v=%b rd=%0d res=%h cnt=%0d want v=%b rd=%0d res=%h cnt=%0d", i,
                 bus.wb_valid, bus.wb_rd_addr, bus.wb_result, bus.retire_count, m_wb_valid, m_wb_rd, m_wb_result, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.me_valid = 1;
    for (int i = 0; i < 65536; i++) begin
      bus.me_rd_addr = AW'(i);
      bus.me_result = DW'(i);
      tick();
    end
    n_cmp++;
    if (bus.retire_count !== CW'(m_cnt) || m_cnt != 65535) begin
      n_err++;
      $display("FAIL wrap_full: got %0d want 65535 (model %0d)", bus.retire_count, m_cnt);
    end
    tick();
    n_cmp++;
    if (bus.retire_count !== 16'd0) begin
      n_err++;
      $display("FAIL wrap_zero: got %0d want 0", bus.retire_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward_basic();
    test_back_to_back();
    test_stall();
    test_invalid();
    test_async_reset();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
